pingpong_ram_ctrl: RTL and testbench
====================================

# pingpong_ram_ctrl

Executes the write and read commands that the ping-pong manager issues for the two-bank transpose buffer. It writes each incoming frame row-major into the selected RAM bank and reads a stored frame back column-major, so the output stream is the matrix transpose. It reports bank completion through `wr_finish_0/1` and `rd_finish_0/1` to the manager. It sits between the manager, the input stream and the two dual-port RAM banks.

## Interface
- `ROWS`, 4: matrix rows per frame (≥2)
- `COLS`, 3: matrix columns per frame (≥2)
- `DATA_W`, 16: sample width
- `ADDR_W`, `$clog2(ROWS*COLS)`: bank address width

- `clk`  in  1  single clock; everything is synchronous to its rising edge
- `rst`  in  1  reset, synchronous, active-high
- `wr_command`  in  1  start-write pulse from manager
- `wr_ram_number`  in  1  target bank for writes; valid from the cycle after `wr_command`
- `rd_command`  in  1  start-read pulse from manager
- `rd_ram_number`  in  1  source bank for reads; valid from the cycle after `rd_command`
- `data_in`, `data_in_valid`  in  DATA_W, 1  input stream, no backpressure
- `wr_finish_0`, `wr_finish_1`  out  1, 1  last beat of the frame written to bank 0 / bank 1
- `rd_finish_0`, `rd_finish_1`  out  1, 1  last beat of the frame read from bank 0 / bank 1 presented
- `ramN_we`, `ramN_waddr`, `ramN_wdata` (N=0,1)  out  1, ADDR_W, DATA_W  bank write port
- `ramN_re`, `ramN_raddr` (N=0,1)  out  1, ADDR_W  bank read port
- `ramN_rdata` (N=0,1)  in  DATA_W  bank read data, 1-cycle latency
- `data_out`, `data_out_valid`  out  DATA_W, 1  transposed output stream

## Operation
- **Writer FSM: W_IDLE → W_ARM → W_RUN.**
  - W_IDLE + `wr_command` → W_ARM.
  - W_ARM lasts one cycle: latch `wr_ram_number` into `wsel` and clear the write address. A `data_in_valid` beat in this cycle is written as beat 0.
  - W_RUN: each `data_in_valid` writes `data_in` to bank `wsel` at `waddr`, then `waddr` increments.
- **Write completion.**
  - `wr_finish_<wsel>` is combinational from registered state: `data_in_valid && waddr==ROWS*COLS-1` in W_ARM/W_RUN.
  - If `wr_command` is asserted in the same cycle, go to W_ARM (back-to-back frame). Otherwise go to W_IDLE.
- **Writer boundary cases.**
  - A beat that coincides with `wr_command` is part of the previous frame when the writer is running. It is dropped when the writer is in W_IDLE.
  - A `wr_command` while in W_RUN and not on the last beat is ignored.
- **Reader FSM: R_IDLE → R_ARM → R_RUN → R_DRAIN.**
  - R_ARM: latch `rd_ram_number` into `rsel` and clear `r` and `c`.
  - R_RUN issues one read per cycle to `raddr = r*COLS + c`. `r` runs from 0 to ROWS-1 as the inner loop; `c` runs from 0 to COLS-1 as the outer loop.
  - `raddr` is kept incrementally: add COLS on each step; on `r` wrap, set it to `c+1`. No multiplier.
  - After the read at (ROWS-1, COLS-1), go to R_DRAIN for one cycle.
- **Read data path.**
  - `data_out` is `ramN_rdata` muxed by `rsel` delayed one cycle.
  - `data_out_valid` is `ramN_re` delayed one cycle.
  - `rd_finish_<rsel>` pulses in the same cycle as the last `data_out_valid`.
  - R_DRAIN → R_ARM if a read is pending, else → R_IDLE.
- **Pending read.** A `rd_command` in any state other than R_IDLE sets a one-deep `rd_pending` flag. The flag is consumed on the R_DRAIN→R_ARM transition, and `rd_ram_number` is sampled in that R_ARM cycle.
- **Concurrency.** The writer and reader are independent. The manager guarantees that `wsel != rsel` while both are active; this block does not check it.

## Timing
- **Reset values:** all outputs 0; FSMs in W_IDLE/R_IDLE; counters and `rd_pending` cleared. A reset in mid-frame abandons the frame with no finish pulse.
- **Write latency:** a write is issued in the same cycle as its `data_in_valid` beat (combinational `we`/`waddr`/`wdata` from registered `waddr` and `wsel`).
- **Read latency:**
  - `rd_command` (cycle 0) → R_ARM (cycle 1) → first `re` (cycle 2) → first `data_out_valid` (cycle 3).
  - A frame occupies ROWS*COLS consecutive output cycles with no gaps.
- **Finish pulses:** `wr_finish_*` and `rd_finish_*` are always exactly one cycle wide.

## Configuration
- `PINGPONG_ERR_EN` defined: adds output `err[1:0]`, sticky and cleared only by `rst`.
  - `err[0]`: `wr_command` ignored in W_RUN, or a beat dropped in W_IDLE.
  - `err[1]`: `rd_command` arrived while `rd_pending` was already set.
- Not defined: port `err` and its logic are absent; behaviour is otherwise identical.

## Structure
- `pingpong_pkg`: writer and reader state enums (one-hot), `bank_sel_t` (1 bit), and the default ROWS/COLS constants.
- Sub-module `transpose_addr_gen`: the `r`/`c` counters, incremental `raddr`, and a last-flag, with start/step inputs. The reader FSM instantiates it.

## Test plan
- **Single frame, ROWS=4, COLS=3, bank 0.**
  - Stimulus: `wr_command`, then beats 0..11.
  - Required: `wr_finish_0` on beat 11. `rd_command` then yields `data_out` 0,3,6,9,1,4,7,10,2,5,8,11 and `rd_finish_0` on 11.
- **Back-to-back frames.**
  - Stimulus: `wr_command` on the last beat of the bank-0 frame, then next frame 100..111 to bank 1.
  - Required: no lost beats; bank 1 holds 100..111; the bank-1 readout starts 100,103,106,109.
- **Pending read.**
  - Stimulus: `rd_command` during a bank-0 readout.
  - Required: the bank-1 readout starts 3 cycles after `rd_finish_0`, with `rd_ram_number` sampled then.
- **Idle beats.**
  - Stimulus: `data_in_valid` with no command.
  - Required: no `ramN_we`.
  - With `PINGPONG_ERR_EN`: `err[0]`=1.
- **Reset at beat 5 of a write.**
  - Required: all outputs 0 the next cycle; no finish pulse. A following full frame works normally.
- **Gapped input.**
  - Stimulus: `data_in_valid` toggling 1,0,1.
  - Required: `waddr` advances only on valid beats; `wr_finish` only on the 12th beat.

Source files
------------

// File: rtl/pingpong_pkg.sv
// rtl/pingpong_pkg.sv - shared types and default frame geometry for the ping-pong transpose buffer
package pingpong_pkg;

  localparam int DEFAULT_ROWS = 4;
  localparam int DEFAULT_COLS = 3;

  typedef logic bank_sel_t;

  typedef enum logic [2:0] {
    W_IDLE = 3'b001,
    W_ARM  = 3'b010,
    W_RUN  = 3'b100
  } w_state_t;

  typedef enum logic [3:0] {
    R_IDLE  = 4'b0001,
    R_ARM   = 4'b0010,
    R_RUN   = 4'b0100,
    R_DRAIN = 4'b1000
  } r_state_t;

endpackage

// File: rtl/pingpong_ram_ctrl_if.sv
// rtl/pingpong_ram_ctrl_if.sv - one dual-port RAM bank port (write side, read side, 1-cycle read data)
interface pingpong_ram_ctrl_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16
);
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              re;
  logic [ADDR_W-1:0] raddr;
  logic [DATA_W-1:0] rdata;

  modport master (output we, waddr, wdata, re, raddr, input rdata);
  modport slave  (input we, waddr, wdata, re, raddr, output rdata);
endinterface

// File: rtl/transpose_addr_gen.sv
// rtl/transpose_addr_gen.sv - column-major read address walk (r inner, c outer) kept without a multiplier
module transpose_addr_gen #(
  parameter int ROWS   = 4,
  parameter int COLS   = 3,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              step,
  output logic [ADDR_W-1:0] raddr,
  output logic              last
);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

  logic [RW-1:0] r;
  logic [CW-1:0] c;

  assign last = (r == RW'(ROWS - 1)) && (c == CW'(COLS - 1));

  always_ff @(posedge clk) begin
    if (rst || start) begin
      r     <= '0;
      c     <= '0;
      raddr <= '0;
    end else if (step) begin
      // On row wrap the next column's first element sits at address c+1.
      if (r == RW'(ROWS - 1)) begin
        r     <= '0;
        c     <= c + 1'b1;
        raddr <= ADDR_W'(c) + ADDR_W'(1);
      end else begin
        r     <= r + 1'b1;
        raddr <= raddr + ADDR_W'(COLS);
      end
    end
  end

endmodule

// File: rtl/pingpong_ram_ctrl.sv
// rtl/pingpong_ram_ctrl.sv - row-major writer / column-major reader for a two-bank transpose buffer
// Optional PINGPONG_ERR_EN adds a sticky err[1:0] output.
module pingpong_ram_ctrl
  import pingpong_pkg::*;
#(
  parameter int ROWS   = DEFAULT_ROWS,
  parameter int COLS   = DEFAULT_COLS,
  parameter int DATA_W = 16,
  parameter int ADDR_W = $clog2(ROWS * COLS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_command,
  input  bank_sel_t         wr_ram_number,
  input  logic              rd_command,
  input  bank_sel_t         rd_ram_number,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_in_valid,
  output logic              wr_finish_0,
  output logic              wr_finish_1,
  output logic              rd_finish_0,
  output logic              rd_finish_1,
  pingpong_ram_ctrl_if.master ram0,
  pingpong_ram_ctrl_if.master ram1,
  output logic [DATA_W-1:0] data_out,
`ifdef PINGPONG_ERR_EN
  output logic [1:0]        err,
`endif
  output logic              data_out_valid
);
  localparam int DEPTH = ROWS * COLS;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  w_state_t          w_state, w_state_nx;
  bank_sel_t         wsel, wsel_nx, w_bank;
  logic [ADDR_W-1:0] waddr, waddr_nx, w_addr_eff;
  logic              w_beat, w_last;

  // In W_ARM the bank and address registers are still being loaded, so the
  // beat-0 write uses the incoming bank number and address 0 directly.
  always_comb begin
    w_state_nx = w_state;
    wsel_nx    = wsel;
    waddr_nx   = waddr;
    w_bank     = (w_state == W_ARM) ? wr_ram_number : wsel;
    w_addr_eff = (w_state == W_ARM) ? '0 : waddr;
    w_beat     = (w_state != W_IDLE) && data_in_valid;
    w_last     = w_beat && (w_addr_eff == LAST_ADDR);
    unique case (w_state)
      W_IDLE: if (wr_command) w_state_nx = W_ARM;
      W_ARM: begin
        wsel_nx    = wr_ram_number;
        waddr_nx   = w_beat ? ADDR_W'(1) : '0;
        w_state_nx = W_RUN;
      end
      W_RUN: begin
        if (w_last) w_state_nx = wr_command ? W_ARM : W_IDLE;
        else if (w_beat) waddr_nx = waddr + 1'b1;
      end
      default: w_state_nx = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state <= W_IDLE;
      wsel    <= 1'b0;
      waddr   <= '0;
    end else begin
      w_state <= w_state_nx;
      wsel    <= wsel_nx;
      waddr   <= waddr_nx;
    end
  end

  assign ram0.we     = w_beat && (w_bank == 1'b0);
  assign ram1.we     = w_beat && (w_bank == 1'b1);
  assign ram0.waddr  = ram0.we ? w_addr_eff : '0;
  assign ram1.waddr  = ram1.we ? w_addr_eff : '0;
  assign ram0.wdata  = ram0.we ? data_in : '0;
  assign ram1.wdata  = ram1.we ? data_in : '0;
  assign wr_finish_0 = w_last && (w_bank == 1'b0);
  assign wr_finish_1 = w_last && (w_bank == 1'b1);

  r_state_t          r_state, r_state_nx;
  bank_sel_t         rsel, rsel_nx, rsel_d;
  logic              rd_pending, rd_pending_nx;
  logic              re, re_d, last_d;
  logic              ag_start, ag_step, ag_last;
  logic [ADDR_W-1:0] ag_raddr;

  transpose_addr_gen #(
    .ROWS   (ROWS),
    .COLS   (COLS),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk   (clk),
    .rst   (rst),
    .start (ag_start),
    .step  (ag_step),
    .raddr (ag_raddr),
    .last  (ag_last)
  );

  always_comb begin
    r_state_nx    = r_state;
    rsel_nx       = rsel;
    rd_pending_nx = rd_pending;
    ag_start      = 1'b0;
    ag_step       = 1'b0;
    re            = 1'b0;
    if (rd_command && (r_state != R_IDLE)) rd_pending_nx = 1'b1;
    unique case (r_state)
      R_IDLE: if (rd_command) r_state_nx = R_ARM;
      R_ARM: begin
        rsel_nx    = rd_ram_number;
        ag_start   = 1'b1;
        r_state_nx = R_RUN;
      end
      R_RUN: begin
        re      = 1'b1;
        ag_step = 1'b1;
        if (ag_last) r_state_nx = R_DRAIN;
      end
      R_DRAIN: begin
        // A command landing in the drain cycle itself is honoured too.
        if (rd_pending || rd_command) begin
          r_state_nx    = R_ARM;
          rd_pending_nx = 1'b0;
        end else begin
          r_state_nx = R_IDLE;
        end
      end
      default: r_state_nx = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= R_IDLE;
      rsel       <= 1'b0;
      rd_pending <= 1'b0;
      rsel_d     <= 1'b0;
      re_d       <= 1'b0;
      last_d     <= 1'b0;
    end else begin
      r_state    <= r_state_nx;
      rsel       <= rsel_nx;
      rd_pending <= rd_pending_nx;
      rsel_d     <= rsel;
      re_d       <= re;
      last_d     <= re && ag_last;
    end
  end

  assign ram0.re        = re && (rsel == 1'b0);
  assign ram1.re        = re && (rsel == 1'b1);
  assign ram0.raddr     = ram0.re ? ag_raddr : '0;
  assign ram1.raddr     = ram1.re ? ag_raddr : '0;
  assign data_out_valid = re_d;
  assign data_out       = re_d ? (rsel_d ? ram1.rdata : ram0.rdata) : '0;
  assign rd_finish_0    = last_d && (rsel_d == 1'b0);
  assign rd_finish_1    = last_d && (rsel_d == 1'b1);

`ifdef PINGPONG_ERR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 2'b00;
    end else begin
      if (((w_state == W_RUN) && wr_command && !w_last) ||
          ((w_state == W_IDLE) && data_in_valid))
        err[0] <= 1'b1;
      if (rd_command && rd_pending)
        err[1] <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pingpong_ram_ctrl.sv
// tb/tb_pingpong_ram_ctrl.sv - directed self-checking bench for pingpong_ram_ctrl (4x3 frames, 16-bit samples)
module tb_pingpong_ram_ctrl;
  localparam int ROWS = 4;
  localparam int COLS = 3;
  localparam int N    = ROWS * COLS;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_command, wr_ram_number, rd_command, rd_ram_number;
  logic [15:0] data_in;
  logic        data_in_valid;
  logic        wr_finish_0, wr_finish_1, rd_finish_0, rd_finish_1;
  logic [15:0] data_out;
  logic        data_out_valid;
`ifdef PINGPONG_ERR_EN
  logic [1:0]  err;
`endif

  pingpong_ram_ctrl_if #(.ADDR_W(4), .DATA_W(16)) ram0_if ();
  pingpong_ram_ctrl_if #(.ADDR_W(4), .DATA_W(16)) ram1_if ();

  pingpong_ram_ctrl #(.ROWS(ROWS), .COLS(COLS), .DATA_W(16), .ADDR_W(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .wr_command     (wr_command),
    .wr_ram_number  (wr_ram_number),
    .rd_command     (rd_command),
    .rd_ram_number  (rd_ram_number),
    .data_in        (data_in),
    .data_in_valid  (data_in_valid),
    .wr_finish_0    (wr_finish_0),
    .wr_finish_1    (wr_finish_1),
    .rd_finish_0    (rd_finish_0),
    .rd_finish_1    (rd_finish_1),
    .ram0           (ram0_if),
    .ram1           (ram1_if),
    .data_out       (data_out),
`ifdef PINGPONG_ERR_EN
    .err            (err),
`endif
    .data_out_valid (data_out_valid)
  );

  always #5 clk = ~clk;

  logic [15:0] mem0 [0:15];
  logic [15:0] mem1 [0:15];
  logic [15:0] rd0 = '0, rd1 = '0;
  assign ram0_if.rdata = rd0;
  assign ram1_if.rdata = rd1;

  always @(posedge clk) begin
    if (ram0_if.we) mem0[ram0_if.waddr] <= ram0_if.wdata;
    if (ram1_if.we) mem1[ram1_if.waddr] <= ram1_if.wdata;
    if (ram0_if.re) rd0 <= mem0[ram0_if.raddr];
    if (ram1_if.re) rd1 <= mem1[ram1_if.raddr];
  end

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  logic [15:0] out_q[$];
  int          oc_q[$];
  int          f0_q[$];
  int          f1_q[$];

  always @(negedge clk) begin
    if (data_out_valid) begin
      out_q.push_back(data_out);
      oc_q.push_back(cyc_n);
    end
    if (rd_finish_0) f0_q.push_back(cyc_n);
    if (rd_finish_1) f1_q.push_back(cyc_n);
  end

  int n_checks = 0;
  int n_fail   = 0;
  int w_fin_cnt, w_fin_beat, w_wrong;
  int tr [0:N-1] = '{0, 3, 6, 9, 1, 4, 7, 10, 2, 5, 8, 11};

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ctl_vec();
    return {23'd0, ram0_if.we, ram1_if.we, ram0_if.re, ram1_if.re, data_out_valid,
            wr_finish_0, wr_finish_1, rd_finish_0, rd_finish_1};
  endfunction

  function automatic logic [31:0] bus_any();
    return {31'd0, (|ram0_if.waddr) | (|ram1_if.waddr) | (|ram0_if.wdata) | (|ram1_if.wdata) |
                   (|ram0_if.raddr) | (|ram1_if.raddr) | (|data_out)};
  endfunction

  task automatic write_frame(input logic bank, input int base, input bit gapped,
                             input bit cmd_last, input bit start_cmd);
    int  i = 0;
    int  guard = 0;
    bit  g = 1'b0;
    bit  v;
    w_fin_cnt = 0; w_fin_beat = -1; w_wrong = 0;
    if (start_cmd) begin
      wr_command = 1'b1; data_in_valid = 1'b0;
      step();
      wr_command = 1'b0;
    end
    wr_ram_number = bank;
    while (i < N && guard < 100) begin
      v = !gapped || !g;
      data_in_valid = v;
      data_in = v ? 16'(base + i) : 16'hDEAD;
      wr_command = cmd_last && v && (i == N - 1);
      @(negedge clk);
      if (bank ? wr_finish_1 : wr_finish_0) begin w_fin_cnt++; w_fin_beat = i; end
      if (bank ? wr_finish_0 : wr_finish_1) w_wrong++;
      step();
      if (v) i++;
      g = ~g;
      guard++;
    end
    data_in_valid = 1'b0;
    wr_command = 1'b0;
  endtask

  task automatic check_mem(input logic bank, input int base, input string tag);
    int bad = 0;
    for (int a = 0; a < N; a++)
      if ((bank ? mem1[a] : mem0[a]) !== 16'(base + a)) bad++;
    check(tag, bad, 0);
  endtask

  task automatic read_frame(input logic bank, input int base, input string tag);
    int t0;
    int n = 0;
    out_q.delete(); oc_q.delete(); f0_q.delete(); f1_q.delete();
    rd_command = 1'b1;
    t0 = cyc_n;
    step();
    rd_command = 1'b0;
    rd_ram_number = bank;
    while (out_q.size() < N && n < 60) begin step(); n++; end
    step();
    check({tag, "_count"}, out_q.size(), N);
    for (int k = 0; k < N && k < out_q.size(); k++)
      check({tag, "_data"}, out_q[k], base + tr[k]);
    check({tag, "_latency"}, oc_q[0] - t0, 3);
    check({tag, "_span"}, oc_q[N-1] - oc_q[0], N - 1);
    check({tag, "_fin_cnt"}, bank ? f1_q.size() : f0_q.size(), 1);
    check({tag, "_fin_cyc"}, bank ? f1_q[0] : f0_q[0], oc_q[N-1]);
    check({tag, "_fin_other"}, bank ? f0_q.size() : f1_q.size(), 0);
  endtask

  initial begin
    int n;
    bit fin_seen;
    logic [31:0] acc;
    rst = 1'b1; wr_command = 1'b0; wr_ram_number = 1'b0; rd_command = 1'b0;
    rd_ram_number = 1'b0; data_in = '0; data_in_valid = 1'b0;
    repeat (2) step();
    @(negedge clk);
    check("reset_ctl", ctl_vec(), 0);
    check("reset_bus", bus_any(), 0);
    step();
    rst = 1'b0;

    // Single frame into bank 0, then transposed readout.
    write_frame(1'b0, 0, 1'b0, 1'b0, 1'b1);
    check("t1_wfin_cnt", w_fin_cnt, 1);
    check("t1_wfin_beat", w_fin_beat, N - 1);
    check("t1_wfin_wrong", w_wrong, 0);
    check_mem(1'b0, 0, "t1_mem0");
    read_frame(1'b0, 0, "t1_rd");

    // Back-to-back frames: next command on the last beat.
    write_frame(1'b0, 200, 1'b0, 1'b1, 1'b1);
    check("b2b_fin0_cnt", w_fin_cnt, 1);
    check("b2b_fin0_beat", w_fin_beat, N - 1);
    write_frame(1'b1, 100, 1'b0, 1'b0, 1'b0);
    check("b2b_fin1_cnt", w_fin_cnt, 1);
    check("b2b_fin1_beat", w_fin_beat, N - 1);
    check_mem(1'b0, 200, "b2b_mem0");
    check_mem(1'b1, 100, "b2b_mem1");

    // Pending read issued mid-readout; bank number changes only after rd_finish_0.
    out_q.delete(); oc_q.delete(); f0_q.delete(); f1_q.delete();
    rd_ram_number = 1'b0;
    rd_command = 1'b1;
    step();
    rd_command = 1'b0;
    repeat (5) step();
    rd_command = 1'b1;
    step();
    rd_command = 1'b0;
    n = 0; fin_seen = 1'b0;
    while (!fin_seen && n < 60) begin
      @(negedge clk);
      if (rd_finish_0) fin_seen = 1'b1;
      step();
      n++;
    end
    check("pend_fin0_seen", fin_seen, 1);
    rd_ram_number = 1'b1;
    n = 0;
    while (out_q.size() < 2 * N && n < 60) begin step(); n++; end
    step();
    check("pend_count", out_q.size(), 2 * N);
    for (int k = 0; k < N && k < out_q.size(); k++)
      check("pend_bank0_data", out_q[k], 200 + tr[k]);
    for (int k = N; k < 2 * N && k < out_q.size(); k++)
      check("pend_bank1_data", out_q[k], 100 + tr[k - N]);
    check("pend_gap", oc_q[N] - f0_q[0], 3);
    check("pend_fin1_cnt", f1_q.size(), 1);
    check("pend_fin1_cyc", f1_q[0], oc_q[2*N-1]);

    // Idle beats must never reach a bank.
    acc = '0;
    for (int k = 0; k < 3; k++) begin
      data_in_valid = 1'b1; data_in = 16'hBEEF;
      @(negedge clk);
      acc = acc | {30'd0, ram0_if.we, ram1_if.we};
      step();
    end
    data_in_valid = 1'b0;
    check("idle_we", acc, 0);
`ifdef PINGPONG_ERR_EN
    check("idle_err0", err[0], 1);
`endif

    // Reset in the middle of a frame.
    wr_command = 1'b1;
    step();
    wr_command = 1'b0;
    wr_ram_number = 1'b0;
    w_fin_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      data_in_valid = 1'b1; data_in = 16'(50 + k);
      @(negedge clk);
      if (wr_finish_0 || wr_finish_1) w_fin_cnt++;
      step();
    end
    data_in_valid = 1'b1; data_in = 16'd55; rst = 1'b1;
    step();
    rst = 1'b0; data_in_valid = 1'b0;
    @(negedge clk);
    check("rst_mid_ctl", ctl_vec(), 0);
    check("rst_mid_bus", bus_any(), 0);
    check("rst_mid_nofin", w_fin_cnt, 0);
`ifdef PINGPONG_ERR_EN
    check("rst_mid_err", err, 0);
`endif
    step();
    write_frame(1'b0, 300, 1'b0, 1'b0, 1'b1);
    check("post_rst_fin_cnt", w_fin_cnt, 1);
    check("post_rst_fin_beat", w_fin_beat, N - 1);
    check_mem(1'b0, 300, "post_rst_mem0");
    read_frame(1'b0, 300, "post_rst_rd");

    // Gapped input stream into bank 1.
    write_frame(1'b1, 400, 1'b1, 1'b0, 1'b1);
    check("gap_fin_cnt", w_fin_cnt, 1);
    check("gap_fin_beat", w_fin_beat, N - 1);
    check("gap_fin_wrong", w_wrong, 0);
    check_mem(1'b1, 400, "gap_mem1");
    read_frame(1'b1, 400, "gap_rd");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1);
  end

endmodule
